// File: rtl/connect4_turn_ctrl.sv
// Connect4 game/turn controller.
// Sequences NUM_PLAYERS players through a game. It counts accepted moves so
// that a full board ends the game as a tie, and it forfeits a turn when the
// optional per-move timeout expires. The starting player rotates from one
// completed game to the next. All outputs come straight from registers.
module connect4_turn_ctrl #(
  parameter  int NUM_PLAYERS  = 2,
  parameter  int MAX_MOVES    = 42,
  parameter  int MOVE_TIMEOUT = 0,
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int CW = $clog2(MAX_MOVES + 1),
  localparam int TW = (MOVE_TIMEOUT > 0) ? $clog2(MOVE_TIMEOUT + 1) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          restart,
  input  logic          move_done,
  input  logic          move_win,
  output logic [1:0]    game_state,
  output logic [PW-1:0] current_player,
  output logic [PW-1:0] winner,
  output logic          game_over,
  output logic          tie,
  output logic [CW-1:0] move_count,
  output logic          timeout_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_END  = 2'b11
  } state_t;

  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [CW-1:0] FULL_BOARD  = CW'(MAX_MOVES);
  localparam logic [TW-1:0] TIMER_LAST  = TW'((MOVE_TIMEOUT > 0) ? MOVE_TIMEOUT - 1 : 0);

  state_t        state_reg,     state_next;
  logic [PW-1:0] player_reg,    player_next;
  logic [PW-1:0] first_reg,     first_next;
  logic [PW-1:0] winner_reg,    winner_next;
  logic          over_reg,      over_next;
  logic          tie_reg,       tie_next;
  logic [CW-1:0] count_reg,     count_next;
  logic [TW-1:0] timer_reg,     timer_next;
  logic          timeout_reg,   timeout_next;
  logic [CW-1:0] count_inc;

  // Player rotation wraps after the last player index.
  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    return (p == LAST_PLAYER) ? '0 : p + PW'(1);
  endfunction

  assign count_inc = count_reg + CW'(1);

  // State and datapath registers; reset aborts any game in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      player_reg  <= '0;
      first_reg   <= '0;
      winner_reg  <= '0;
      over_reg    <= 1'b0;
      tie_reg     <= 1'b0;
      count_reg   <= '0;
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      player_reg  <= player_next;
      first_reg   <= first_next;
      winner_reg  <= winner_next;
      over_reg    <= over_next;
      tie_reg     <= tie_next;
      count_reg   <= count_next;
      timer_reg   <= timer_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state and next-output logic; everything holds unless a rule fires.
  always_comb begin
    state_next   = state_reg;
    player_next  = player_reg;
    first_next   = first_reg;
    winner_next  = winner_reg;
    over_next    = over_reg;
    tie_next     = tie_reg;
    count_next   = count_reg;
    timer_next   = timer_reg;
    timeout_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next  = ST_PLAY;
          player_next = first_reg;
          count_next  = '0;
          timer_next  = '0;
          winner_next = '0;
          tie_next    = 1'b0;
        end
      end

      ST_PLAY: begin
        if (restart) begin
          // Abort: the same player opens the next game.
          state_next = ST_IDLE;
        end else if (move_done) begin
          timer_next = '0;
          count_next = count_inc;
          if (move_win) begin
            // A win on the last free cell still counts as a win.
            state_next  = ST_END;
            over_next   = 1'b1;
            winner_next = player_reg;
          end else if (count_inc == FULL_BOARD) begin
            state_next = ST_END;
            over_next  = 1'b1;
            tie_next   = 1'b1;
          end else begin
            player_next = next_player(player_reg);
          end
        end else if (MOVE_TIMEOUT > 0) begin
          if (timer_reg == TIMER_LAST) begin
            // Turn forfeited: pass to the next player without counting a move.
            timeout_next = 1'b1;
            player_next  = next_player(player_reg);
            timer_next   = '0;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
      end

      ST_END: begin
        if (restart) begin
          state_next = ST_IDLE;
          over_next  = 1'b0;
          tie_next   = 1'b0;
          first_next = next_player(first_reg);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign game_state     = state_reg;
  assign current_player = player_reg;
  assign winner         = winner_reg;
  assign game_over      = over_reg;
  assign tie            = tie_reg;
  assign move_count     = count_reg;
  assign timeout_pulse  = timeout_reg;

endmodule
